// File: rtl/ibex_csr_access_ctrl.sv
// ibex_csr_access_ctrl
// Initiator for a bank of CSR primitives. It takes read/write/set/clear
// requests on a valid/ready channel. Each access runs as a read-modify-write
// sequence IDLE -> READ -> WRITE -> RESP. The pre-operation value and an
// error flag are returned on a valid/ready response channel.

module ibex_csr_access_ctrl #(
    parameter int unsigned        NumCsr       = 4,
    parameter int unsigned        AddrW        = 4,
    parameter logic [NumCsr-1:0]  ReadOnlyMask = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [AddrW-1:0]         req_addr_i,
    input  logic [31:0]              req_wdata_i,

    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [31:0]              resp_rdata_o,
    output logic                     resp_error_o,

    output logic [NumCsr-1:0]        csr_wr_en_o,
    output logic [31:0]              csr_wr_data_o,
    input  logic [NumCsr*32-1:0]     csr_rd_data_i,
    input  logic [NumCsr-1:0]        csr_rd_error_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [AddrW-1:0]      addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           old_q, old_d;
    logic                  err_q, err_d;
    logic [NumCsr-1:0]     wr_en_q, wr_en_d;
    logic [31:0]           wr_data_q, wr_data_d;

    // Decode of the captured address.
    logic [NumCsr-1:0]     sel_hit;
    logic [31:0]           sel_rdata;
    logic                  sel_rderr;
    logic                  sel_ro;
    logic                  mapped;
    logic                  modifying;
    logic                  acc_err;
    logic                  do_write;
    logic [31:0]           new_val;

    // State register.
    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every flop samples the pre-edge values regardless of process order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk, RESP waits for the consumer.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pure decodes of the state register.
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
    end

    // Select the addressed CSR. The full AddrW bits are compared, so an
    // address at or above NumCsr never aliases onto a real CSR.
    always_comb begin
        sel_hit   = '0;
        sel_rdata = '0;
        sel_rderr = 1'b0;
        sel_ro    = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (addr_q == AddrW'(i)) begin
                sel_hit[i] = 1'b1;
                sel_rdata  = csr_rd_data_i[32*i +: 32];
                sel_rderr  = csr_rd_error_i[i];
                sel_ro     = ReadOnlyMask[i];
            end
        end
        mapped = |sel_hit;
    end

    // Operation result and write qualification, evaluated against read data
    // sampled in READ.
    always_comb begin
        modifying = (op_q == OP_WRITE) ||
                    (((op_q == OP_SET) || (op_q == OP_CLEAR)) && (wdata_q != '0));
        acc_err   = !mapped || sel_rderr || (sel_ro && modifying);
        do_write  = modifying && !acc_err;
        unique case (op_q)
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = sel_rdata | wdata_q;
            OP_CLEAR: new_val = sel_rdata & ~wdata_q;
            default:  new_val = sel_rdata;
        endcase
    end

    // Datapath next values: capture on accept; sample and pre-compute in READ.
    // The write strobe is registered at the READ->WRITE edge, so it is high for
    // exactly the WRITE cycle and never combinationally depends on req_*.
    always_comb begin
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        old_d     = old_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = op_e'(req_op_i);
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                end
            end
            READ: begin
                old_d = sel_rdata;
                err_d = acc_err;
                if (do_write) begin
                    wr_en_d   = sel_hit;
                    wr_data_d = new_val;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset also drops the write strobe asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            old_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            old_q     <= old_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign resp_rdata_o  = old_q;
    assign resp_error_o  = err_q;
    assign csr_wr_en_o   = wr_en_q;
    assign csr_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Directed testbench for ibex_csr_access_ctrl: a small CSR bank model answers
// reads and absorbs write pulses; every expectation is a hand-computed constant.

module tb_ibex_csr_access_ctrl;

    localparam int NumCsr = 4;
    localparam int AddrW  = 4;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready_o;
    logic [1:0]            req_op;
    logic [AddrW-1:0]      req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid_o;
    logic                  resp_ready;
    logic [31:0]           resp_rdata_o;
    logic                  resp_error_o;
    logic [NumCsr-1:0]     csr_wr_en_o;
    logic [31:0]           csr_wr_data_o;
    logic [NumCsr*32-1:0]  csr_rd_data;
    logic [NumCsr-1:0]     csr_rd_error;

    int n_cmp = 0;
    int n_fail = 0;

    ibex_csr_access_ctrl #(
        .NumCsr       (NumCsr),
        .AddrW        (AddrW),
        .ReadOnlyMask (4'b1000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata_o),
        .resp_error_o   (resp_error_o),
        .csr_wr_en_o    (csr_wr_en_o),
        .csr_wr_data_o  (csr_wr_data_o),
        .csr_rd_data_i  (csr_rd_data),
        .csr_rd_error_i (csr_rd_error)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR bank model: preload port plus the primitive write port.
    logic [31:0] bank [NumCsr];
    logic        load_en;
    int          load_idx;
    logic [31:0] load_val;

    always @(posedge clk) begin
        if (load_en) begin
            bank[load_idx] <= load_val;
        end else begin
            for (int i = 0; i < NumCsr; i++)
                if (csr_wr_en_o[i]) bank[i] <= csr_wr_data_o;
        end
    end

    always_comb begin
        csr_rd_data = '0;
        for (int i = 0; i < NumCsr; i++) csr_rd_data[32*i +: 32] = bank[i];
    end

    // Write-pulse monitor, sampled mid-cycle.
    int                pulse_cnt = 0;
    logic [NumCsr-1:0] last_en = '0;
    logic [31:0]       last_data = '0;
    int                wr_cycle = 0;

    always @(negedge clk) begin
        if (|csr_wr_en_o) begin
            pulse_cnt <= pulse_cnt + 1;
            last_en   <= csr_wr_en_o;
            last_data <= csr_wr_data_o;
            wr_cycle  <= cyc + 1;
        end
    end

    // Per-access observations.
    int          hs_edge;
    int          resp_cycle;
    int          n_pulse;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] val);
        load_idx = idx;
        load_val = val;
        load_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Present a request at a negedge and hold it until accepted.
    task automatic issue(input string tag, input logic [1:0] op,
                         input logic [AddrW-1:0] addr, input logic [31:0] wd);
        int budget;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        budget    = 0;
        while (!req_ready_o && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " accept"}, 32'(req_ready_o), 32'd1);
        hs_edge = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for the response; complete the handshake if resp_ready is high.
    task automatic collect(input string tag);
        int budget;
        budget = 0;
        while (!resp_valid_o && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " resp_valid"}, 32'(resp_valid_o), 32'd1);
        resp_cycle = cyc + 1;
        got_rdata  = resp_rdata_o;
        got_err    = resp_error_o;
        if (resp_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic access(input string tag, input logic [1:0] op,
                          input logic [AddrW-1:0] addr, input logic [31:0] wd);
        int snap;
        snap = pulse_cnt;
        issue(tag, op, addr, wd);
        collect(tag);
        n_pulse = pulse_cnt - snap;
    endtask

    logic [AddrW-1:0] b2b_addr [8];
    int               first_hs;
    int               prev_hs;
    int               b2b_snap;

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        csr_rd_error = '0;
        load_en      = 1'b0;
        load_idx     = 0;
        load_val     = '0;

        load(0, 32'h0000_0F0F);
        load(1, 32'h0000_0001);
        load(2, 32'h0000_00A5);
        load(3, 32'h0000_0033);

        // Reset state.
        check("rst req_ready",  32'(req_ready_o),  32'd1);
        check("rst resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst resp_rdata", resp_rdata_o,      32'd0);
        check("rst resp_error", 32'(resp_error_o), 32'd0);
        check("rst wr_en",      32'(csr_wr_en_o),  32'd0);
        check("rst wr_data",    csr_wr_data_o,     32'd0);
        rst = 1'b0;

        // Reset while a response is pending.
        resp_ready = 1'b0;
        access("rstresp", OP_RD, 4'd2, 32'd0);
        check("rstresp rdata before", got_rdata, 32'h0000_00A5);
        rst = 1'b1;
        #1;
        check("rstresp resp_valid", 32'(resp_valid_o), 32'd0);
        check("rstresp req_ready",  32'(req_ready_o),  32'd1);
        check("rstresp rdata",      resp_rdata_o,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;

        // Reset during the write cycle drops the strobe at once.
        issue("rstwr", OP_WR, 4'd2, 32'h0000_0055);
        @(posedge clk);
        #1;
        check("rstwr wr_en live",   32'(csr_wr_en_o), 32'h4);
        check("rstwr wr_data live", csr_wr_data_o,    32'h0000_0055);
        rst = 1'b1;
        #1;
        check("rstwr wr_en",     32'(csr_wr_en_o),  32'd0);
        check("rstwr req_ready", 32'(req_ready_o),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Plain read; CSR2 is untouched by the aborted write.
        access("rd2", OP_RD, 4'd2, 32'd0);
        check("rd2 rdata",   got_rdata,               32'h0000_00A5);
        check("rd2 err",     32'(got_err),            32'd0);
        check("rd2 pulses",  32'(n_pulse),            32'd0);
        check("rd2 latency", 32'(resp_cycle - hs_edge), 32'd3);

        // Write and readback.
        access("wr1", OP_WR, 4'd1, 32'hDEAD_BEEF);
        check("wr1 rdata",      got_rdata,             32'h0000_0001);
        check("wr1 err",        32'(got_err),          32'd0);
        check("wr1 pulses",     32'(n_pulse),          32'd1);
        check("wr1 en",         32'(last_en),          32'h2);
        check("wr1 data",       last_data,             32'hDEAD_BEEF);
        check("wr1 wr latency", 32'(wr_cycle - hs_edge), 32'd2);
        check("wr1 latency",    32'(resp_cycle - hs_edge), 32'd3);
        access("rd1", OP_RD, 4'd1, 32'd0);
        check("rd1 rdata",  got_rdata,    32'hDEAD_BEEF);
        check("rd1 pulses", 32'(n_pulse), 32'd0);

        // Set and clear.
        access("set0", OP_SET, 4'd0, 32'h0000_00F0);
        check("set0 rdata",  got_rdata,    32'h0000_0F0F);
        check("set0 pulses", 32'(n_pulse), 32'd1);
        check("set0 en",     32'(last_en), 32'h1);
        check("set0 data",   last_data,    32'h0000_0FFF);
        access("clr0", OP_CLR, 4'd0, 32'h0000_000F);
        check("clr0 rdata",  got_rdata,    32'h0000_0FFF);
        check("clr0 pulses", 32'(n_pulse), 32'd1);
        check("clr0 data",   last_data,    32'h0000_0FF0);
        access("set0z", OP_SET, 4'd0, 32'd0);
        check("set0z rdata",  got_rdata,    32'h0000_0FF0);
        check("set0z err",    32'(got_err), 32'd0);
        check("set0z pulses", 32'(n_pulse), 32'd0);

        // Errors.
        access("wr5", OP_WR, 4'd5, 32'h1234_5678);
        check("wr5 err",    32'(got_err), 32'd1);
        check("wr5 rdata",  got_rdata,    32'd0);
        check("wr5 pulses", 32'(n_pulse), 32'd0);
        access("rd4", OP_RD, 4'd4, 32'd0);
        check("rd4 err",    32'(got_err), 32'd1);
        check("rd4 rdata",  got_rdata,    32'd0);
        access("wr3ro", OP_WR, 4'd3, 32'hFFFF_FFFF);
        check("wr3ro err",    32'(got_err), 32'd1);
        check("wr3ro rdata",  got_rdata,    32'h0000_0033);
        check("wr3ro pulses", 32'(n_pulse), 32'd0);
        access("rd3", OP_RD, 4'd3, 32'd0);
        check("rd3 err",   32'(got_err), 32'd0);
        check("rd3 rdata", got_rdata,    32'h0000_0033);
        access("set3z", OP_SET, 4'd3, 32'd0);
        check("set3z err",    32'(got_err), 32'd0);
        check("set3z pulses", 32'(n_pulse), 32'd0);
        csr_rd_error = 4'b0001;
        access("wr0rderr", OP_WR, 4'd0, 32'hAAAA_5555);
        csr_rd_error = 4'b0000;
        check("wr0rderr err",    32'(got_err), 32'd1);
        check("wr0rderr rdata",  got_rdata,    32'h0000_0FF0);
        check("wr0rderr pulses", 32'(n_pulse), 32'd0);

        // Backpressure: response held for five cycles with a new request waiting.
        resp_ready = 1'b0;
        access("bp", OP_WR, 4'd1, 32'hCAFE_0001);
        check("bp rdata",  got_rdata,    32'hDEAD_BEEF);
        check("bp pulses", 32'(n_pulse), 32'd1);
        req_op    = OP_RD;
        req_addr  = 4'd2;
        req_wdata = 32'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold resp_valid", 32'(resp_valid_o), 32'd1);
            check("bp hold rdata",      resp_rdata_o,      32'hDEAD_BEEF);
            check("bp hold err",        32'(resp_error_o), 32'd0);
            check("bp hold req_ready",  32'(req_ready_o),  32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release req_ready",  32'(req_ready_o),  32'd1);
        check("bp release resp_valid", 32'(resp_valid_o), 32'd0);
        hs_edge = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        check("bp accepted", 32'(req_ready_o), 32'd0);
        req_valid = 1'b0;
        collect("bp2");
        check("bp2 rdata",   got_rdata,                 32'h0000_00A5);
        check("bp2 latency", 32'(resp_cycle - hs_edge), 32'd3);

        // Back-to-back writes at one access per four cycles.
        b2b_addr = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        b2b_snap = pulse_cnt;
        first_hs = 0;
        prev_hs  = 0;
        for (int k = 0; k < 8; k++) begin
            access("b2b", OP_WR, b2b_addr[k], 32'h1000_0000 + 32'(k));
            check("b2b pulses", 32'(n_pulse),   32'd1);
            check("b2b en",     32'(last_en),   32'd1 << b2b_addr[k]);
            check("b2b data",   last_data,      32'h1000_0000 + 32'(k));
            check("b2b err",    32'(got_err),   32'd0);
            if (k == 0) first_hs = hs_edge;
            else check("b2b spacing", 32'(hs_edge - prev_hs), 32'd4);
            prev_hs = hs_edge;
        end
        check("b2b total pulses", 32'(pulse_cnt - b2b_snap), 32'd8);
        check("b2b span",         32'(cyc - first_hs),       32'd31);
        access("rdb2b", OP_RD, 4'd1, 32'd0);
        check("rdb2b rdata", got_rdata, 32'h1000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_csr_access_ctrl.md
Name: ibex_csr_access_ctrl

Overview:
- Initiator side of the CSR primitive write/read interface.
- Accepts CSR access requests over a valid/ready channel and performs read, write, set or clear operations against a bank of NumCsr CSR primitives.
- Drives each primitive's write enable and write data, and samples its read data and read error.
- Returns the pre-operation value and an error flag over a valid/ready response channel; sits between the instruction decode/CSR-instruction path and the CSR bank.

Parameters:
- NumCsr, 4, number of attached CSR primitives (1..16).
- AddrW, 4, request address width; addresses >= NumCsr are unmapped.
- ReadOnlyMask, 4'b0000, bit i set means CSR i rejects modifying ops.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  controller can accept a request.
- req_op_i  input  2  operation: 00 read, 01 write, 10 set, 11 clear.
- req_addr_i  input  AddrW  target CSR index.
- req_wdata_i  input  32  write data or bit mask.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  consumer accepts response.
- resp_rdata_o  output  32  CSR value before the operation.
- resp_error_o  output  1  access error.
- csr_wr_en_o  output  NumCsr  one-hot write enable, one per CSR.
- csr_wr_data_o  output  32  shared write data to all CSRs.
- csr_rd_data_i  input  NumCsr*32  concatenated read data; CSR i occupies bits [32i+31:32i].
- csr_rd_error_i  input  NumCsr  per-CSR read error.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (rst_i high, asynchronous):
  - state goes to IDLE.
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_error_o=0.
  - csr_wr_en_o=0, csr_wr_data_o=0.
  - Captured op/addr/wdata registers clear to 0.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i && req_ready_o, capture op, addr and wdata, then go to READ.
- READ (1 cycle):
  - If addr >= NumCsr: old=0, err=1.
  - Otherwise: old=csr_rd_data_i[addr], err=csr_rd_error_i[addr].
  - Register old and err, then go to WRITE.
- WRITE (1 cycle): compute the new value.
  - write: new=wdata.
  - set: new=old|wdata.
  - clear: new=old&~wdata.
  - Suppress the write for: op=read; set/clear with wdata==0; err=1; addr unmapped.
  - If ReadOnlyMask[addr]=1 and op is write, or op is set/clear with nonzero mask: set err=1 and suppress the write.
  - If not suppressed: csr_wr_en_o[addr]=1 for exactly this cycle, csr_wr_data_o=new. csr_wr_data_o holds its last value otherwise.
  - Go to RESP.
- RESP:
  - resp_valid_o=1; resp_rdata_o=old; resp_error_o=err.
  - Outputs are stable while resp_valid_o && !resp_ready_i.
  - On resp_ready_i, go to IDLE with resp_valid_o=0.
- Latency:
  - Request handshake at edge N, write pulse in cycle N+2, resp_valid_o first high in cycle N+3.
  - With resp_ready_i held high, the next request is accepted at edge N+4.
  - Throughput is one access per 4 cycles.
- Since csr_wr_en_o is one-hot-or-zero, at most one write is issued per request.
- Requests presented while req_ready_o=0 are ignored; the requester holds them.
- Read data is sampled in READ only. Changes on csr_rd_data_i in later states do not affect the response.
- Reset mid-operation: state returns to IDLE immediately, any pending response is discarded, and csr_wr_en_o drops to 0 asynchronously.
- Address comparison uses the full AddrW bits; there is no aliasing or truncation.
- No combinational path from req_* to csr_* or resp_*; all outputs are registered.

Test Plan:
- Reset and read:
  - Assert rst_i mid-RESP: resp_valid_o=0 and req_ready_o=1 immediately.
  - After release, read addr 2 with CSR2=0x0000_00A5: resp_rdata_o=0x0000_00A5, err=0, csr_wr_en_o stays 0.
- Write and readback:
  - Write 0xDEAD_BEEF to addr 1 with CSR1=0x1: one-cycle csr_wr_en_o=4'b0010 and csr_wr_data_o=0xDEAD_BEEF in cycle N+2; resp_rdata_o=0x1.
  - A following read returns 0xDEAD_BEEF.
- Set and clear:
  - CSR0=0x0F0F: set 0x00F0 writes 0x0FFF; clear 0x000F then writes 0x0FF0.
  - Set with mask 0: no csr_wr_en_o pulse, resp_rdata_o=0x0FF0.
- Errors:
  - Write to addr 5 (NumCsr=4): err=1, rdata=0, no write.
  - ReadOnlyMask=4'b1000, write to addr 3: err=1, no write.
  - Read of addr 3: err=0.
  - csr_rd_error_i[0]=1 during a write to addr 0: err=1, no write.
- Backpressure:
  - Hold resp_ready_i=0 for 5 cycles: resp_valid_o, resp_rdata_o and resp_error_o stay stable, req_ready_o=0, and a new req_valid_i is not accepted.
  - Release: accepted at the edge after the response handshake.
- Back-to-back throughput:
  - 8 consecutive writes with resp_ready_i=1 complete in 32 cycles.
  - Each produces exactly one csr_wr_en_o pulse to the correct index.
